// File: rtl/vga_timing_pkg.sv
// Shared 480p raster timing constants and types.
//   P480_* : 640x480@60 per-axis region lengths and totals
//   CW_480P: coordinate width able to hold H_TOTAL-1 and V_TOTAL-1
//   coord_t: coordinate type at the 480p width
//   region_t: per-axis raster region, in scan order
package vga_timing_pkg;

  localparam int P480_H_ACTIVE = 640;
  localparam int P480_H_FP     = 16;
  localparam int P480_H_SYNC   = 96;
  localparam int P480_H_BP     = 48;
  localparam int P480_H_TOTAL  = P480_H_ACTIVE + P480_H_FP + P480_H_SYNC + P480_H_BP;

  localparam int P480_V_ACTIVE = 480;
  localparam int P480_V_FP     = 10;
  localparam int P480_V_SYNC   = 2;
  localparam int P480_V_BP     = 33;
  localparam int P480_V_TOTAL  = P480_V_ACTIVE + P480_V_FP + P480_V_SYNC + P480_V_BP;

  localparam int CW_480P = 10;

  typedef logic [CW_480P-1:0] coord_t;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FRONT,
    REG_SYNC,
    REG_BACK
  } region_t;

endpackage

// File: rtl/display_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK region FSM.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clr        : synchronous load of position 0 / ACTIVE (wins over i_en)
//   i_en         : advance one position
//   o_count      : registered position 0..TOTAL-1
//   o_region_nxt : region the counter enters on the next edge (lets the top
//                  register its outputs aligned with o_count)
//   o_wrap       : combinational, high when this edge takes TOTAL-1 back to 0
module display_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output region_t       o_region_nxt,
  output logic          o_wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // Last position of each region.
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] FP_END   = CW'(ACTIVE + FP - 1);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] TOT_END  = CW'(TOTAL - 1);

  if ((2 ** CW) < TOTAL) begin : g_width_check
    $error("display_axis_counter: CW=%0d cannot hold TOTAL-1=%0d", CW, TOTAL - 1);
  end

  logic [CW-1:0] r_count;
  region_t       r_region;
  logic [CW-1:0] w_count_nxt;
  region_t       w_region_nxt;
  logic          w_wrap;

  always_comb begin
    w_count_nxt  = r_count;
    w_region_nxt = r_region;
    w_wrap       = 1'b0;
    if (i_clr) begin
      w_count_nxt  = '0;
      w_region_nxt = REG_ACTIVE;
    end else if (i_en) begin
      if (r_count == TOT_END) begin
        w_count_nxt = '0;
        w_wrap      = 1'b1;
      end else begin
        w_count_nxt = r_count + 1'b1;
      end
      case (r_region)
        REG_ACTIVE: if (r_count == ACT_END)  w_region_nxt = REG_FRONT;
        REG_FRONT:  if (r_count == FP_END)   w_region_nxt = REG_SYNC;
        REG_SYNC:   if (r_count == SYNC_END) w_region_nxt = REG_BACK;
        default:    if (r_count == TOT_END)  w_region_nxt = REG_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_region <= REG_ACTIVE;
    end else begin
      r_count  <= w_count_nxt;
      r_region <= w_region_nxt;
    end
  end

  assign o_count      = r_count;
  assign o_region_nxt = w_region_nxt;
  assign o_wrap       = w_wrap;

endmodule

// File: rtl/display_timings_480p.sv
// 640x480@60 raster timing generator on the pixel clock.
//   clk_pixel   : pixel clock
//   reset       : asynchronous active-low reset
//   clk_locked  : PLL lock; low holds every output at its reset value
//   sx, sy      : current column / line
//   de          : visible-area data enable
//   hsync/vsync : syncs, asserted level set by H_SYNC_POL / V_SYNC_POL
//   line_start  : strobe at sx==0 of every line
//   frame_start : strobe at (0,0)
//   frame_count : frames started since lock (first frame reads 1), wraps
// All outputs are registered and describe the same (sx,sy) in a given cycle.
module display_timings_480p
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = P480_H_ACTIVE,
  parameter int   H_FP       = P480_H_FP,
  parameter int   H_SYNC     = P480_H_SYNC,
  parameter int   H_BP       = P480_H_BP,
  parameter int   V_ACTIVE   = P480_V_ACTIVE,
  parameter int   V_FP       = P480_V_FP,
  parameter int   V_SYNC     = P480_V_SYNC,
  parameter int   V_BP       = P480_V_BP,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   CW         = CW_480P
) (
  input  logic          clk_pixel,
  input  logic          reset,
  input  logic          clk_locked,
  output logic [CW-1:0] sx,
  output logic [CW-1:0] sy,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  logic        r_running;
  logic        r_de;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_line_start;
  logic        r_frame_start;
  logic [15:0] r_frame_count;

  region_t w_h_region_nxt;
  region_t w_v_region_nxt;
  logic    w_h_wrap;
  logic    w_v_wrap;
  logic    w_clr;
  logic    w_ls_nxt;
  logic    w_fs_nxt;

  // Counters sit at (0,0) while unlocked, and the first locked edge loads
  // (0,0) rather than advancing, so the first pixel appears one edge after lock.
  assign w_clr = ~clk_locked | ~r_running;

  display_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h (
    .clk          (clk_pixel),
    .rst_n        (reset),
    .i_clr        (w_clr),
    .i_en         (1'b1),
    .o_count      (sx),
    .o_region_nxt (w_h_region_nxt),
    .o_wrap       (w_h_wrap)
  );

  display_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v (
    .clk          (clk_pixel),
    .rst_n        (reset),
    .i_clr        (w_clr),
    .i_en         (w_h_wrap),
    .o_count      (sy),
    .o_region_nxt (w_v_region_nxt),
    .o_wrap       (w_v_wrap)
  );

  // Strobes fire on the start-up load and on each wrap.
  assign w_ls_nxt = clk_locked & (~r_running | w_h_wrap);
  assign w_fs_nxt = clk_locked & (~r_running | w_v_wrap);

  // Registered from the counters' next-state so they line up with sx/sy.
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      r_running     <= 1'b0;
      r_de          <= 1'b0;
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_running     <= clk_locked;
      r_de          <= clk_locked & (w_h_region_nxt == REG_ACTIVE)
                                  & (w_v_region_nxt == REG_ACTIVE);
      r_hsync       <= (clk_locked && (w_h_region_nxt == REG_SYNC)) ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync       <= (clk_locked && (w_v_region_nxt == REG_SYNC)) ? V_SYNC_POL : ~V_SYNC_POL;
      r_line_start  <= w_ls_nxt;
      r_frame_start <= w_fs_nxt;
      if (!clk_locked) begin
        r_frame_count <= '0;
      end else if (w_fs_nxt) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule
